// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO widths and pointer helpers
package fifo_pkg;

  localparam int FIFO_ADDR_W = 5;
  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;

  // Binary to reflected Gray code; callers truncate to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - combinational Gray to binary converter shared by both FIFO sides
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int W = FIFO_PTR_W
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each binary bit is the XOR of every Gray bit at or above its position.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < W; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter, write pointer, full/level; WRARB_ALMOST_FULL_EN adds almost-full
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DATA_W = FIFO_DATA_W,
  parameter int AF_THR = 28
) (
  input  logic                    wr_clk,
  input  logic                    wr_rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  input  logic [ADDR_W:0]         wq2_rd_ptr,
  output logic                    mem_wr_en,
  output logic [ADDR_W-1:0]       mem_wr_addr,
  output logic [DATA_W-1:0]       mem_wr_data,
  output logic [ADDR_W:0]         wr_ptr,
  output logic                    wr_full,
  output logic [ADDR_W:0]         wr_level,
  output logic                    wr_almost_full
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Starting from the last index makes requester 0 the first candidate.
  localparam logic [RR_W-1:0] RR_RESET = RR_W'(N_REQ - 1);

  logic [PTR_W-1:0]  bin_q, bin_d;
  logic [PTR_W-1:0]  gray_q, gray_d;
  logic [PTR_W-1:0]  level_q, level_d;
  logic [PTR_W-1:0]  rd_bin;
  logic [PTR_W-1:0]  full_cmp;
  logic              full_q, full_d;
  logic [RR_W-1:0]   rr_last_q, rr_last_d;
  logic [RR_W-1:0]   grant_idx;
  logic              grant_vld;
  logic [DATA_W-1:0] data_arr [N_REQ];

  fifo_gray2bin #(.W(PTR_W)) u_rd_g2b (
    .gray_i (wq2_rd_ptr),
    .bin_o  (rd_bin)
  );

  for (genvar i = 0; i < N_REQ; i++) begin : g_data_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Round-robin search: first asserted request after the last granted index, wrapping.
  always_comb begin
    int cand;
    logic [RR_W-1:0] cand_idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(rr_last_q) + k) % N_REQ;
      cand_idx = RR_W'(cand);
      if (!grant_vld && req[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Accept the winner only when not full; reset forces the write port idle.
  always_comb begin
    ack       = '0;
    mem_wr_en = 1'b0;
    if (wr_rst_n && grant_vld && !full_q) begin
      ack[grant_idx] = 1'b1;
      mem_wr_en      = 1'b1;
    end
  end

  assign mem_wr_data = data_arr[grant_idx];
  assign mem_wr_addr = bin_q[ADDR_W-1:0];

  // Next pointer, full and level all use the post-write pointer and the current synced read pointer.
  always_comb begin
    bin_d     = bin_q + PTR_W'(mem_wr_en);
    gray_d    = PTR_W'(bin2gray(32'(bin_d)));
    full_cmp  = {~wq2_rd_ptr[ADDR_W:ADDR_W-1], wq2_rd_ptr[ADDR_W-2:0]};
    full_d    = (gray_d == full_cmp);
    level_d   = bin_d - rd_bin;
    rr_last_d = mem_wr_en ? grant_idx : rr_last_q;
  end

  // Pointer, status and arbitration state registers.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      bin_q     <= '0;
      gray_q    <= '0;
      full_q    <= 1'b0;
      level_q   <= '0;
      rr_last_q <= RR_RESET;
    end else begin
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      full_q    <= full_d;
      level_q   <= level_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign wr_ptr   = gray_q;
  assign wr_full  = full_q;
  assign wr_level = level_q;

`ifdef WRARB_ALMOST_FULL_EN
  logic af_q;

  // Almost-full is registered alongside full from the same next-level value.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (int'(level_d) >= AF_THR);
    end
  end

  assign wr_almost_full = af_q;
`else
  // Threshold has no effect without the comparator; this folds to constant 0.
  assign wr_almost_full = 1'b0 && (AF_THR >= 0);
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int PW = AW + 1;
  localparam int AF = 28;

  logic          wr_clk   = 1'b0;
  logic          wr_rst_n = 1'b0;
  logic [N-1:0]  req      = '0;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack;
  logic [PW-1:0] wq2_rd_ptr;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [PW-1:0] wr_ptr;
  logic          wr_full;
  logic [PW-1:0] wr_level;
  logic          wr_almost_full;

  logic [DW-1:0] dat [N];
  int rd_cnt   = 0;
  int checks   = 0;
  int failures = 0;

  // Reference state: total words written, last winner, registered status.
  int m_wr    = 0;
  int m_last  = N - 1;
  int m_level = 0;
  bit m_full  = 1'b0;
  bit m_af    = 1'b0;

  always #5 wr_clk = ~wr_clk;

  function automatic int g6(input int b);
    int v;
    v = b & 63;
    return v ^ (v >> 1);
  endfunction

  assign wq2_rd_ptr = PW'(g6(rd_cnt));
  assign req_data   = {dat[3], dat[2], dat[1], dat[0]};

  fifo_wr_arbiter #(
    .N_REQ  (N),
    .ADDR_W (AW),
    .DATA_W (DW),
    .AF_THR (AF)
  ) dut (
    .wr_clk         (wr_clk),
    .wr_rst_n       (wr_rst_n),
    .req            (req),
    .req_data       (req_data),
    .ack            (ack),
    .wq2_rd_ptr     (wq2_rd_ptr),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .wr_ptr         (wr_ptr),
    .wr_full        (wr_full),
    .wr_level       (wr_level),
    .wr_almost_full (wr_almost_full)
  );

  function automatic int exp_grant();
    for (int k = 1; k <= N; k++) begin
      if (req[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit exp_we();
    return !m_full && (exp_grant() >= 0);
  endfunction

  function automatic int lvl_next();
    return (m_wr + (exp_we() ? 1 : 0) - rd_cnt) & 63;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model advances on the same edges as the design.
  always @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      m_wr    <= 0;
      m_last  <= N - 1;
      m_level <= 0;
      m_full  <= 1'b0;
      m_af    <= 1'b0;
    end else begin
      if (exp_we()) begin
        m_wr   <= m_wr + 1;
        m_last <= exp_grant();
      end
      m_level <= lvl_next();
      m_full  <= (lvl_next() == 32);
`ifdef WRARB_ALMOST_FULL_EN
      m_af    <= (lvl_next() >= AF);
`else
      m_af    <= 1'b0;
`endif
    end
  end

  // Every cycle out of reset, compare all outputs against the model mid-cycle.
  always @(negedge wr_clk) begin
    if (wr_rst_n) begin
      chk("ack", int'(ack), exp_we() ? (1 << exp_grant()) : 0);
      chk("mem_wr_en", int'(mem_wr_en), int'(exp_we()));
      chk("mem_wr_addr", int'(mem_wr_addr), m_wr & 31);
      if (exp_we()) chk("mem_wr_data", int'(mem_wr_data), int'(dat[exp_grant()]));
      chk("wr_ptr", int'(wr_ptr), g6(m_wr));
      chk("wr_full", int'(wr_full), int'(m_full));
      chk("wr_level", int'(wr_level), m_level);
      chk("wr_almost_full", int'(wr_almost_full), int'(m_af));
    end
  end

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] ack_tbl [4];
    logic [N-1:0] mix_tbl [12];
    logic [PW-1:0] prev_ptr;
    int seen_wrap;
    int cyc;
    ack_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    mix_tbl = '{4'b1011, 4'b1011, 4'b1011, 4'b0110, 4'b0110, 4'b0000,
                4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1000, 4'b0001};
    dat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    // Test 1: reset holds the write port idle even with requests present.
    req = 4'b1111;
    #2;
    chk("rst_ack", int'(ack), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_ptr", int'(wr_ptr), 0);
    step();
    req = 4'b0000;
    step();
    wr_rst_n = 1'b1;
    repeat (10) step();
    chk("idle_wr_en", int'(mem_wr_en), 0);
    chk("idle_ptr", int'(wr_ptr), 0);
    chk("idle_full", int'(wr_full), 0);
    chk("idle_level", int'(wr_level), 0);

    // Test 2: all requesters held, rotation 0,1,2,3,0..., addresses count up to bin=17.
    req = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      #1;
      chk("rr_ack", int'(ack), int'(ack_tbl[i % 4]));
      chk("rr_addr", int'(mem_wr_addr), i);
      step();
    end
    chk("burst_level", int'(wr_level), 17);

    // Test 6a: reset mid-burst clears outputs without waiting for a clock edge.
    #1;
    wr_rst_n = 1'b0;
    #1;
    chk("async_ptr", int'(wr_ptr), 0);
    chk("async_level", int'(wr_level), 0);
    chk("async_full", int'(wr_full), 0);
    chk("async_addr", int'(mem_wr_addr), 0);
    chk("async_ack", int'(ack), 0);
    step();
    wr_rst_n = 1'b1;
    #1;
    chk("restart_ack0", int'(ack), 1);
    step();
    #1;
    chk("restart_ack1", int'(ack), 2);
    step();

    // Test 3: a single requester fills the FIFO; full after write 32, then frozen.
    wr_rst_n = 1'b0;
    req = 4'b0100;
    #2;
    wr_rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      chk("fill_level", int'(wr_level), i);
`ifdef WRARB_ALMOST_FULL_EN
      if (i == 27) chk("af_at_27", int'(wr_almost_full), 0);
      if (i == 28) chk("af_at_28", int'(wr_almost_full), 1);
`else
      if (i == 28) chk("af_off_28", int'(wr_almost_full), 0);
`endif
      if (i == 31) chk("fill_full_31", int'(wr_full), 0);
    end
    chk("full_flag", int'(wr_full), 1);
    chk("full_ptr", int'(wr_ptr), 6'b110000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_ack", int'(ack), 0);
      chk("full_wr_en", int'(mem_wr_en), 0);
      step();
      chk("full_ptr_hold", int'(wr_ptr), 6'b110000);
    end

    // Test 4: one read frees a slot; full drops, one write, full again.
    rd_cnt = 1;
    step();
    chk("unfull_flag", int'(wr_full), 0);
    chk("unfull_level", int'(wr_level), 31);
    #1;
    chk("unfull_ack", int'(ack), 4);
    step();
    chk("refull_flag", int'(wr_full), 1);
    chk("refull_level", int'(wr_level), 32);
    chk("refull_ptr", int'(wr_ptr), 6'b110001);

    // Test 5: reads and writes together push the write pointer through its wrap.
    dat = '{8'h5A, 8'h3C, 8'hE1, 8'h0F};
    prev_ptr  = wr_ptr;
    seen_wrap = 0;
    cyc       = 0;
    while (m_wr < 70 && cyc < 300) begin
      if (rd_cnt < m_wr) rd_cnt = rd_cnt + 1;
      step();
      cyc++;
      if (wr_ptr != prev_ptr) begin
        if (prev_ptr == 6'b100000 && wr_ptr == 6'b000000) seen_wrap = 1;
        prev_ptr = wr_ptr;
      end
    end
    chk("wrap_budget", int'(cyc < 300), 1);
    chk("wrap_seen", seen_wrap, 1);

    // Mixed request patterns, withdrawals and idle gaps with reads still flowing.
    for (int i = 0; i < 12; i++) begin
      req = mix_tbl[i];
      if (rd_cnt < m_wr) rd_cnt = rd_cnt + 1;
      step();
    end
    req = 4'b0000;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
